// File: rtl/coin_acceptor_pkg.sv
// coin_acceptor_pkg
//   Shared types and constants for the coin acceptor front end.
//   - state_t   : acceptor FSM states (2 bits)
//   - COIN_W    : number of coin slots
//   - COIN_0..3 : one-hot codes presented on coin_out
//   - is_onehot : true when exactly one slot bit is set
package coin_acceptor_pkg;

  localparam int COIN_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STROBE   = 2'd1,
    WAIT_REL = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  localparam logic [COIN_W-1:0] COIN_0 = 4'b0001;
  localparam logic [COIN_W-1:0] COIN_1 = 4'b0010;
  localparam logic [COIN_W-1:0] COIN_2 = 4'b0100;
  localparam logic [COIN_W-1:0] COIN_3 = 4'b1000;

  function automatic logic is_onehot(input logic [COIN_W-1:0] v);
    return $onehot(v);
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce
//   One slot channel: 2-FF synchroniser followed by a stability counter.
//   The debounced level only follows the synchronised input once the two
//   have disagreed for DEB_CYCLES consecutive cycles; a single cycle of
//   agreement restarts the count.
// Ports:
//   clk50m : clock
//   res    : synchronous reset, active-high
//   raw    : asynchronous switch input
//   deb    : debounced level
module coin_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk50m,
  input  logic res,
  input  logic raw,
  output logic deb
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk50m) begin
    if (res) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      deb   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // DEB_CYCLES-th consecutive disagreeing cycle: commit new level
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor
//   Front end for the vending-machine core. Debounces four coin slots,
//   accepts exactly one coin per insertion and rejects multi-coin or
//   stuck-slot insertions.
// Ports:
//   clk50m   : sole clock, 50 MHz
//   res      : synchronous reset, active-high
//   coin_raw : raw slot switches, bit i = coin type i
//   coin_out : one-hot code of last accepted coin, held
//   coin_stb : one-cycle pulse, coin_out newly valid
//   coin_err : one-cycle pulse, insertion rejected
//   busy     : high whenever the FSM is not in IDLE
//   tally    : (only with COIN_ACCEPTOR_TALLY_EN) four saturating 8-bit
//              per-type accepted-coin counters, field i = type i
// Build option: define COIN_ACCEPTOR_TALLY_EN to add the tally port.
//
// Handshake: coin_stb is a one-cycle valid with no ready; coin_out is
// stable from the cycle before coin_stb until the next acceptance.
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int DEB_CYCLES     = 500000,
  parameter int LOCKOUT_CYCLES = 250000
) (
  input  logic              clk50m,
  input  logic              res,
  input  logic [COIN_W-1:0] coin_raw,
  output logic [COIN_W-1:0] coin_out,
  output logic              coin_stb,
  output logic              coin_err,
  output logic              busy
`ifdef COIN_ACCEPTOR_TALLY_EN
  ,
  output logic [31:0]       tally
`endif
);

  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCKOUT_CYCLES - 1);

  logic [COIN_W-1:0] deb;
  logic [COIN_W-1:0] deb_q;
  logic [COIN_W-1:0] rise;
  logic [LOCK_W-1:0] lock_cnt;

  state_t state;
  state_t state_n;
  logic   accept;
  logic   err_d;
  logic   lock_load;

  for (genvar i = 0; i < COIN_W; i++) begin : g_deb
    coin_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk50m(clk50m),
      .res   (res),
      .raw   (coin_raw[i]),
      .deb   (deb[i])
    );
  end

  assign rise = deb & ~deb_q;
  assign busy = (state != IDLE);

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    err_d     = 1'b0;
    lock_load = 1'b0;
    case (state)
      IDLE: begin
        if (rise != '0) begin
          // Accept only a single coin with no other slot already held
          if (is_onehot(rise) && (deb == rise)) begin
            accept  = 1'b1;
            state_n = STROBE;
          end else begin
            err_d   = 1'b1;
            state_n = WAIT_REL;
          end
        end else if (deb != '0) begin
          // Slot still held after lockout: treat as stuck
          err_d   = 1'b1;
          state_n = WAIT_REL;
        end
      end
      STROBE: begin
        state_n = WAIT_REL;
      end
      WAIT_REL: begin
        if (deb == '0) begin
          lock_load = 1'b1;
          state_n   = LOCKOUT;
        end
      end
      LOCKOUT: begin
        if (lock_cnt == '0) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk50m) begin
    if (res) begin
      state    <= IDLE;
      deb_q    <= '0;
      coin_out <= '0;
      coin_stb <= 1'b0;
      coin_err <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      deb_q    <= deb;
      coin_stb <= (state == STROBE);
      coin_err <= err_d;
      if (accept) begin
        coin_out <= rise;
      end
      // Loaded with N-1 so LOCKOUT spans exactly LOCKOUT_CYCLES cycles
      if (lock_load) begin
        lock_cnt <= LOCK_MAX;
      end else if ((state == LOCKOUT) && (lock_cnt != '0)) begin
        lock_cnt <= lock_cnt - 1'b1;
      end
    end
  end

`ifdef COIN_ACCEPTOR_TALLY_EN
  // Counts on the same edge that raises coin_stb; saturates at 255
  always_ff @(posedge clk50m) begin
    if (res) begin
      tally <= '0;
    end else if (state == STROBE) begin
      for (int i = 0; i < COIN_W; i++) begin
        if (coin_out[i] && (tally[8*i +: 8] != 8'hFF)) begin
          tally[8*i +: 8] <= tally[8*i +: 8] + 8'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor
//   Directed bench for coin_acceptor with DEB_CYCLES=4, LOCKOUT_CYCLES=3.
//   Edge k is the k-th rising clock edge after coin_raw was changed;
//   outputs are sampled 1 ns after a rising edge.
module tb_coin_acceptor;

  localparam int DEB  = 4;
  localparam int LOCK = 3;

  logic       clk = 1'b0;
  logic       res;
  logic [3:0] coin_raw;
  logic [3:0] coin_out;
  logic       coin_stb;
  logic       coin_err;
  logic       busy;
`ifdef COIN_ACCEPTOR_TALLY_EN
  logic [31:0] tally;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int stb_pulses = 0;
  int err_pulses = 0;
  int both_high = 0;
  int stb_snap;
  int err_snap;

  // clock / reset
  always #5 clk = ~clk;

  coin_acceptor #(
    .DEB_CYCLES    (DEB),
    .LOCKOUT_CYCLES(LOCK)
  ) dut (
    .clk50m  (clk),
    .res     (res),
    .coin_raw(coin_raw),
    .coin_out(coin_out),
    .coin_stb(coin_stb),
    .coin_err(coin_err),
    .busy    (busy)
`ifdef COIN_ACCEPTOR_TALLY_EN
    ,
    .tally   (tally)
`endif
  );

  // pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (coin_stb) stb_pulses++;
    if (coin_err) err_pulses++;
    if (coin_stb && coin_err) both_high++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    stb_snap = stb_pulses;
    err_snap = err_pulses;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      step(1);
      k++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  // release all slots and return to IDLE
  task automatic release_all();
    coin_raw = 4'b0000;
    step(12);
    wait_idle(40);
  endtask

  task automatic insert_coin(input logic [3:0] v);
    coin_raw = v;
    step(10);
    release_all();
  endtask

  initial begin
    res      = 1'b1;
    coin_raw = 4'b1111;

    // 1: reset with all slots held
    step(2);
    check("rst_coin_out", {28'd0, coin_out}, 32'h0);
    check("rst_stb", {31'd0, coin_stb}, 32'd0);
    check("rst_err", {31'd0, coin_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef COIN_ACCEPTOR_TALLY_EN
    check("rst_tally", tally, 32'h0);
`endif
    res = 1'b0;
    snap();
    step(10);
    check("stuck_no_stb", stb_pulses - stb_snap, 32'd0);
    check("stuck_coin_out", {28'd0, coin_out}, 32'h0);
    release_all();

    // 2: single coin 0010, held 20 cycles
    snap();
    coin_raw = 4'b0010;
    step(6);
    check("t2_e6_coin_out", {28'd0, coin_out}, 32'h0);
    check("t2_e6_busy", {31'd0, busy}, 32'd0);
    step(1);
    check("t2_e7_coin_out", {28'd0, coin_out}, 32'h2);
    check("t2_e7_stb", {31'd0, coin_stb}, 32'd0);
    check("t2_e7_busy", {31'd0, busy}, 32'd1);
    step(1);
    check("t2_e8_stb", {31'd0, coin_stb}, 32'd1);
    step(1);
    check("t2_e9_stb", {31'd0, coin_stb}, 32'd0);
    step(11);
    check("t2_held_busy", {31'd0, busy}, 32'd1);
    check("t2_one_stb", stb_pulses - stb_snap, 32'd1);
    check("t2_no_err", err_pulses - err_snap, 32'd0);
    coin_raw = 4'b0000;
    step(9);
    check("t2_lockout_busy", {31'd0, busy}, 32'd1);
    step(1);
    check("t2_lockout_end", {31'd0, busy}, 32'd0);

    // 3: bouncing bit 0, then stable
    snap();
    for (int i = 0; i < 6; i++) begin
      coin_raw = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      step(2);
    end
    check("t3_bounce_no_stb", stb_pulses - stb_snap, 32'd0);
    check("t3_bounce_idle", {31'd0, busy}, 32'd0);
    coin_raw = 4'b0001;
    step(6);
    check("t3_e6_coin_out", {28'd0, coin_out}, 32'h2);
    step(1);
    check("t3_e7_coin_out", {28'd0, coin_out}, 32'h1);
    step(1);
    check("t3_e8_stb", {31'd0, coin_stb}, 32'd1);
    step(4);
    check("t3_one_stb", stb_pulses - stb_snap, 32'd1);
    release_all();

    // 4: two coins at once -> reject, then a good coin
    snap();
    coin_raw = 4'b0101;
    step(7);
    check("t4_e7_err", {31'd0, coin_err}, 32'd1);
    check("t4_e7_coin_out", {28'd0, coin_out}, 32'h1);
    step(1);
    check("t4_e8_err", {31'd0, coin_err}, 32'd0);
    step(4);
    check("t4_one_err", err_pulses - err_snap, 32'd1);
    check("t4_no_stb", stb_pulses - stb_snap, 32'd0);
    release_all();
    snap();
    coin_raw = 4'b1000;
    step(7);
    check("t4_good_coin_out", {28'd0, coin_out}, 32'h8);
    step(1);
    check("t4_good_stb", {31'd0, coin_stb}, 32'd1);
    release_all();
    check("t4_good_err", err_pulses - err_snap, 32'd0);

    // 5: second slot added while held is ignored
    coin_raw = 4'b0001;
    step(8);
    check("t5_stb", {31'd0, coin_stb}, 32'd1);
    check("t5_coin_out", {28'd0, coin_out}, 32'h1);
    step(1);
    snap();
    coin_raw = 4'b0101;
    step(10);
    check("t5_add_no_err", err_pulses - err_snap, 32'd0);
    check("t5_add_no_stb", stb_pulses - stb_snap, 32'd0);
    coin_raw = 4'b0000;
    step(9);
    check("t5_lock_busy", {31'd0, busy}, 32'd1);
    step(1);
    check("t5_lock_done", {31'd0, busy}, 32'd0);
    coin_raw = 4'b0100;
    step(7);
    check("t5_coin_out", {28'd0, coin_out}, 32'h4);
    step(1);
    check("t5_stb2", {31'd0, coin_stb}, 32'd1);
    check("t5_no_err", err_pulses - err_snap, 32'd0);
    release_all();
`ifdef COIN_ACCEPTOR_TALLY_EN
    check("tally_mixed", tally, 32'h0101_0102);
`endif

    // 6: reset mid-debounce discards progress
    snap();
    coin_raw = 4'b0010;
    step(3);
    res      = 1'b1;
    coin_raw = 4'b0000;
    step(2);
    res = 1'b0;
    check("t6_coin_out", {28'd0, coin_out}, 32'h0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    step(10);
    check("t6_no_stb", stb_pulses - stb_snap, 32'd0);
    check("t6_no_err", err_pulses - err_snap, 32'd0);
`ifdef COIN_ACCEPTOR_TALLY_EN
    check("t6_tally_rst", tally, 32'h0);
    for (int i = 0; i < 256; i++) begin
      insert_coin(4'b1000);
    end
    check("t6_tally_sat", tally, 32'hFF00_0000);
`endif

    check("stb_err_exclusive", both_high, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Upstream front end for the vending-machine state core.
- Takes four raw, bouncy coin-slot switches and synchronises and debounces each one.
- Accepts exactly one coin per insertion and presents it to the core as a held one-hot code plus a single-cycle step strobe.
- Rejects multi-coin or stuck-slot conditions with an error pulse.

Parameters:
- DEB_CYCLES, 500000: consecutive stable cycles (at 50 MHz, 10 ms) needed to change a debounced level; minimum 2.
- LOCKOUT_CYCLES, 250000: idle cycles enforced after all slots release before the next coin is accepted; minimum 1.

Ports:
- clk50m  in  1  sole clock, 50 MHz.
- res  in  1  synchronous reset, active-high.
- coin_raw  in  4  raw slot switches, asynchronous, bit i = coin type i.
- coin_out  out  4  one-hot code of last accepted coin, held until next acceptance.
- coin_stb  out  1  one-cycle pulse, coin_out newly valid.
- coin_err  out  1  one-cycle pulse, insertion rejected.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk50m. Reset is synchronous, active-high, on port res.
- Reset values: coin_out=0000, coin_stb=0, coin_err=0, busy=0. Synchronisers, debounced levels, edge registers and counters all 0. State=IDLE. Reset mid-debounce or mid-lockout discards all progress.
- Per bit:
  - 2-FF synchroniser feeds the debouncer.
  - Debounce counter clears while the synchronised value equals the debounced level, and increments otherwise.
  - On reaching DEB_CYCLES-1 the debounced level takes the synchronised value and the counter clears.
  - Any single-cycle agreement restarts the count.
- Edge detect: a register holds the previous debounced levels; rise = deb & ~deb_q.
- FSM states:
  - IDLE: if rise != 0:
    - rise one-hot and deb == rise: coin_out <= rise, go STROBE.
    - otherwise: coin_err pulses the next cycle, go WAIT_REL.
    - If deb != 0 with rise == 0 (slot held through lockout): coin_err, go WAIT_REL.
  - STROBE: one cycle; coin_stb registered high in the following cycle; go WAIT_REL.
  - WAIT_REL: when deb == 0000, load the lockout counter and go LOCKOUT. All rises here are ignored, not queued, and raise no error.
  - LOCKOUT: counts LOCKOUT_CYCLES cycles, then IDLE. Rises are ignored.
- Latency: raw bit stable from edge 0:
  - synchronised at edge 2;
  - debounced at edge 2+DEB_CYCLES;
  - coin_out updates at edge 3+DEB_CYCLES;
  - coin_stb high between edges 4+DEB_CYCLES and 5+DEB_CYCLES.
- coin_stb and coin_err are never both high. Each pulses at most once per insertion.
- Counter widths: $clog2 of the respective parameter; no wrap is reachable.

Optional Feature:
- Macro COIN_ACCEPTOR_TALLY_EN.
- Defined:
  - Adds output tally, 32 bits, as four 8-bit fields; field i = accepted coins of type i.
  - A field increments in the same cycle coin_stb asserts for that type.
  - Fields saturate at 255 and reset to 0 on res.
  - Rejected insertions are not counted.
- Undefined: no tally port and no tally logic; all other behaviour identical.

Decomposition:
- Package coin_acceptor_pkg:
  - state enum (IDLE, STROBE, WAIT_REL, LOCKOUT), 2 bits;
  - COIN_W=4;
  - one-hot constants COIN_0..COIN_3.
- Sub-module coin_debounce: one channel (synchroniser + counter + debounced level), parameter DEB_CYCLES, instantiated four times.

Test Plan (DEB_CYCLES=4, LOCKOUT_CYCLES=3):
1. res high for 2 cycles with coin_raw=1111 -> coin_out=0000, coin_stb=0, coin_err=0, busy=0; no stb within 10 cycles after release while raw is still 1111.
2. Raw 0000 -> 0010 at edge 0, held 20 cycles -> coin_out=0010 at edge 7, exactly one coin_stb (edges 8-9), busy high until lockout ends after release.
3. Bit 0 toggling every 2 cycles for 12 cycles, then held 1 -> no stb during bouncing; exactly one stb with coin_out=0001 at 7 cycles after the final stable edge.
4. Raw 0000 -> 0101 same edge -> one coin_err pulse, no coin_stb, coin_out keeps its previous value; release, then 1000 after lockout -> accepted.
5. Hold 0001 until accepted, then add bit 2 (0101) -> ignored, no err; release all, wait 3 lockout cycles, insert 0100 -> accepted with coin_out=0100.
6. res asserted at edge 4 of a debounce of 0010 -> no stb, coin_out=0000; with TALLY_EN, 256 accepted type-3 coins -> tally[31:24]=255.
